hicore_lsu_ctrl: RTL and testbench
==================================

# hicore_lsu_ctrl

Load/store controller between the AGU→LSU pipe stage and the data-memory bus. Accepts one address-generated memory request at a time, sequences it through a command/response bus transaction, aligns and sign/zero-extends load data, merges bus errors into the exception vector and presents one completion per request to ROB writeback. Sole master of the data bus port, with one transaction outstanding at most; honours `flush` without ever abandoning an in-flight bus response.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (DATA_W/8 mask bits)
- INFO_W, `HiCore_ISSUE2ALU_SIZE`, opaque `{rob_ptr,pc,irq,excp}` bundle, passed through
- EXCP_W, `HiCore_EXCP_SIZE`, exception field width (LSBs of info)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_lsu_valid / o_lsu_ready / i_lsu_cancel  in/out/in  1  request handshake and cancel from AGU pipe
- i_lsu_read, i_lsu_unsigned, i_lsu_word, i_lsu_short, i_lsu_byte  in  1  access kind and size (one-hot size)
- i_lsu_addr  in  ADDR_W; i_lsu_wdata  in  DATA_W (lane-replicated); i_lsu_wmask  in  DATA_W/8
- i_lsu_info  in  INFO_W  request tag
- o_bus_cmd_valid / i_bus_cmd_ready  out/in  1  command handshake
- o_bus_cmd_read out 1; o_bus_cmd_addr out ADDR_W (word-aligned, [1:0]=0); o_bus_cmd_wdata out DATA_W; o_bus_cmd_wmask out DATA_W/8
- i_bus_rsp_valid / o_bus_rsp_ready  in/out  1  response handshake
- i_bus_rsp_rdata  in  DATA_W; i_bus_rsp_err  in  1  access fault
- o_wb_valid / i_wb_ready  out/in  1  completion handshake to ROB
- o_wb_data  out  DATA_W  extended load result (0 for stores)
- o_wb_info  out  INFO_W  tag with merged exceptions
- flush  in  1  commit-stage flush

## Operation
- States: IDLE, CMD, RSP, WB, DRAIN (3-bit encoded).
- IDLE: o_lsu_ready=1. Accept on i_lsu_valid & ~i_lsu_cancel & ~flush; latch all request fields. If latched excp≠0 (misaligned from AGU) → WB, no bus access; else → CMD. Cancelled or flushed requests are consumed (ready=1) and dropped.
- CMD: o_bus_cmd_valid=1 with latched fields, addr[1:0] forced 0. cmd handshake → RSP. flush without handshake → IDLE; flush with handshake same cycle → DRAIN.
- RSP: o_bus_rsp_ready=1. rsp handshake → latch rdata/err → WB. flush without rsp → DRAIN; flush with rsp same cycle → IDLE (result dropped).
- DRAIN: o_bus_rsp_ready=1, nothing issued; rsp handshake → IDLE, data discarded.
- WB: o_wb_valid=1. wb handshake → IDLE. flush → IDLE, no completion.
- Load extraction: byte lane = rdata >> (8*addr[1:0]); half lane = rdata >> (16*addr[1]); byte/half sign-extend from bit 7/15 unless unsigned; word unchanged.
- Error merge: rsp_err on load sets excp bit 5 (load access fault), on store bit 7 (store access fault); OR-ed into latched excp; o_wb_data=0 on any exception.
- Flush has priority over every state transition except the DRAIN requirement above.

## Timing
- Reset: state=IDLE, o_lsu_ready=1, o_bus_cmd_valid=0, o_bus_rsp_ready=0, o_wb_valid=0, o_wb_data=0, o_wb_info=0, all command fields 0.
- All outputs registered or decoded from state only; no combinational path from bus/wb inputs to valid outputs.
- Minimum latency (cmd_ready and rsp_valid immediate, wb_ready=1): accept T0, cmd T1, rsp T2, wb T3, next accept T4. Misaligned fast path: accept T0, wb T1.
- Throughput ≤ 1 request per 4 cycles; o_lsu_ready=0 outside IDLE.
- Command fields stable while o_bus_cmd_valid=1 and not handshaken; o_wb_* stable while o_wb_valid=1.
- Reset asserted mid-transaction returns to IDLE immediately; bus side is reset by the same rst_n.

## Structure
- State encoding, excp bit indices (LOAD_ACC_FAULT=5, STORE_ACC_FAULT=7) and size encodings go in the shared HiCore defines package.
- Single sub-module natural: `HiCore_lsu_extend` (combinational lane select + sign/zero extend); FSM and latches in top.

## Test plan
- Load byte signed, addr 0x1003, rdata 0x80FF_0000 → o_wb_data=0xFFFF_FF80, excp unchanged, wb at T3.
- Load half unsigned, addr 0x2002, rdata 0xBEEF_1234 → o_wb_data=0x0000_BEEF; store word addr 0x3000 wdata 0xDEADBEEF mask 4'hF → cmd read=0, wb data 0.
- Request with excp bit 4 set → no cmd_valid ever, wb at T1 with info unchanged.
- Load with i_bus_rsp_err=1 → excp bit 5 set, data 0; store with err → bit 7 set.
- flush in RSP, rsp arrives 3 cycles later → DRAIN absorbs it, no wb_valid, lsu_ready returns next cycle.
- cmd_ready held 0 for 5 cycles, wb_ready 0 for 2 → fields stable throughout; i_lsu_cancel=1 in IDLE → request consumed, no bus activity.

Source files
------------

// File: rtl/hicore_lsu_ctrl_pkg.sv
// Shared HiCore LSU definitions: info bundle widths, exception bit indices,
// controller state and access-size encodings.
package hicore_lsu_ctrl_pkg;

  localparam int unsigned HICORE_EXCP_SIZE      = 16;
  localparam int unsigned HICORE_ROB_PTR_SIZE   = 5;
  localparam int unsigned HICORE_PC_SIZE        = 32;
  // {rob_ptr, pc, irq, excp}
  localparam int unsigned HICORE_ISSUE2ALU_SIZE =
    HICORE_ROB_PTR_SIZE + HICORE_PC_SIZE + 1 + HICORE_EXCP_SIZE;

  localparam int unsigned LOAD_ACC_FAULT  = 5;
  localparam int unsigned STORE_ACC_FAULT = 7;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_CMD   = 3'd1,
    LSU_RSP   = 3'd2,
    LSU_WB    = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // One-hot size flags to encoded size; anything malformed is treated as a word.
  function automatic lsu_size_e size_encode(input logic word, input logic half,
                                            input logic byt);
    lsu_size_e sz;
    case ({word, half, byt})
      3'b010:  sz = SZ_HALF;
      3'b001:  sz = SZ_BYTE;
      default: sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/hicore_lsu_ctrl_extend.sv
// Load data alignment: selects the addressed byte/half lane of a bus word and
// sign- or zero-extends it to the full data width.
module hicore_lsu_ctrl_extend
  import hicore_lsu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_lo_i,
  input  lsu_size_e         size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(rdata_i >> {addr_lo_i, 3'b000});
    half_lane = 16'(rdata_i >> {addr_lo_i[1], 4'b0000});
    data_o    = rdata_i;
    case (size_i)
      SZ_BYTE: data_o = {{(DATA_W-8){~unsigned_i & byte_lane[7]}}, byte_lane};
      SZ_HALF: data_o = {{(DATA_W-16){~unsigned_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/hicore_lsu_ctrl.sv
// Load/store controller: one request at a time through a cmd/rsp bus transaction,
// with load extension, bus-error merge into the exception field and flush handling.
module hicore_lsu_ctrl
  import hicore_lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned INFO_W = HICORE_ISSUE2ALU_SIZE,
  parameter int unsigned EXCP_W = HICORE_EXCP_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_lsu_valid,
  output logic                o_lsu_ready,
  input  logic                i_lsu_cancel,
  input  logic                i_lsu_read,
  input  logic                i_lsu_unsigned,
  input  logic                i_lsu_word,
  input  logic                i_lsu_short,
  input  logic                i_lsu_byte,
  input  logic [ADDR_W-1:0]   i_lsu_addr,
  input  logic [DATA_W-1:0]   i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wmask,
  input  logic [INFO_W-1:0]   i_lsu_info,

  output logic                o_bus_cmd_valid,
  input  logic                i_bus_cmd_ready,
  output logic                o_bus_cmd_read,
  output logic [ADDR_W-1:0]   o_bus_cmd_addr,
  output logic [DATA_W-1:0]   o_bus_cmd_wdata,
  output logic [DATA_W/8-1:0] o_bus_cmd_wmask,

  input  logic                i_bus_rsp_valid,
  output logic                o_bus_rsp_ready,
  input  logic [DATA_W-1:0]   i_bus_rsp_rdata,
  input  logic                i_bus_rsp_err,

  output logic                o_wb_valid,
  input  logic                i_wb_ready,
  output logic [DATA_W-1:0]   o_wb_data,
  output logic [INFO_W-1:0]   o_wb_info,

  input  logic                flush
);

  lsu_state_e          state_q,    state_d;
  logic                read_q,     read_d;
  logic                unsigned_q, unsigned_d;
  lsu_size_e           size_q,     size_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [DATA_W/8-1:0] wmask_q,    wmask_d;
  logic [INFO_W-1:0]   info_q,     info_d;
  logic [DATA_W-1:0]   wb_data_q,  wb_data_d;

  logic [DATA_W-1:0]   ext_data;
  logic [EXCP_W-1:0]   err_excp;
  logic [EXCP_W-1:0]   merged_excp;
  logic                accept;

  hicore_lsu_ctrl_extend #(
    .DATA_W (DATA_W)
  ) u_extend (
    .rdata_i    (i_bus_rsp_rdata),
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data)
  );

  assign accept = i_lsu_valid & ~i_lsu_cancel & ~flush;

  always_comb begin
    err_excp = '0;
    if (i_bus_rsp_err) begin
      if (read_q) err_excp[LOAD_ACC_FAULT]  = 1'b1;
      else        err_excp[STORE_ACC_FAULT] = 1'b1;
    end
    merged_excp = info_q[EXCP_W-1:0] | err_excp;
  end

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    unsigned_d = unsigned_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    info_d     = info_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          read_d     = i_lsu_read;
          unsigned_d = i_lsu_unsigned;
          size_d     = size_encode(i_lsu_word, i_lsu_short, i_lsu_byte);
          addr_d     = i_lsu_addr;
          wdata_d    = i_lsu_wdata;
          wmask_d    = i_lsu_wmask;
          info_d     = i_lsu_info;
          wb_data_d  = '0;
          // AGU-flagged exceptions complete straight away without touching the bus
          if (i_lsu_info[EXCP_W-1:0] != '0) state_d = LSU_WB;
          else                              state_d = LSU_CMD;
        end
      end
      LSU_CMD: begin
        if (flush) begin
          if (i_bus_cmd_ready) state_d = LSU_DRAIN;
          else                 state_d = LSU_IDLE;
        end else if (i_bus_cmd_ready) begin
          state_d = LSU_RSP;
        end
      end
      LSU_RSP: begin
        // A flush racing the response still consumes it, so nothing is left to drain
        if (flush) begin
          if (i_bus_rsp_valid) state_d = LSU_IDLE;
          else                 state_d = LSU_DRAIN;
        end else if (i_bus_rsp_valid) begin
          state_d                = LSU_WB;
          info_d[EXCP_W-1:0]     = merged_excp;
          if (merged_excp != '0 || !read_q) wb_data_d = '0;
          else                              wb_data_d = ext_data;
        end
      end
      LSU_WB: begin
        if (flush || i_wb_ready) state_d = LSU_IDLE;
      end
      LSU_DRAIN: begin
        if (i_bus_rsp_valid) state_d = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      read_q     <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_BYTE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      info_q     <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      unsigned_q <= unsigned_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      info_q     <= info_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign o_lsu_ready     = (state_q == LSU_IDLE);
  assign o_bus_cmd_valid = (state_q == LSU_CMD);
  assign o_bus_rsp_ready = (state_q == LSU_RSP) || (state_q == LSU_DRAIN);
  assign o_wb_valid      = (state_q == LSU_WB);

  assign o_bus_cmd_read  = read_q;
  assign o_bus_cmd_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign o_bus_cmd_wdata = wdata_q;
  assign o_bus_cmd_wmask = wmask_q;
  assign o_wb_data       = wb_data_q;
  assign o_wb_info       = info_q;

endmodule

// File: tb/tb_hicore_lsu_ctrl.sv
// Directed bench for hicore_lsu_ctrl: expected completions are queued when a
// request is driven and compared when the controller presents its writeback.
module tb_hicore_lsu_ctrl;
  import hicore_lsu_ctrl_pkg::*;

  localparam int unsigned IW = HICORE_ISSUE2ALU_SIZE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        lsu_valid = 0, lsu_ready, lsu_cancel = 0, lsu_read = 0, lsu_unsigned = 0;
  logic        lsu_word = 0, lsu_short = 0, lsu_byte = 0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic [IW-1:0] lsu_info = '0;
  logic        cmd_valid, cmd_ready = 0, cmd_read;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid = 0, rsp_ready, rsp_err = 0;
  logic [31:0] rsp_rdata = '0;
  logic        wb_valid, wb_ready = 0;
  logic [31:0] wb_data;
  logic [IW-1:0] wb_info;
  logic        flush = 0;

  hicore_lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .INFO_W(IW), .EXCP_W(HICORE_EXCP_SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_cancel(lsu_cancel),
    .i_lsu_read(lsu_read), .i_lsu_unsigned(lsu_unsigned), .i_lsu_word(lsu_word),
    .i_lsu_short(lsu_short), .i_lsu_byte(lsu_byte), .i_lsu_addr(lsu_addr),
    .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask), .i_lsu_info(lsu_info),
    .o_bus_cmd_valid(cmd_valid), .i_bus_cmd_ready(cmd_ready), .o_bus_cmd_read(cmd_read),
    .o_bus_cmd_addr(cmd_addr), .o_bus_cmd_wdata(cmd_wdata), .o_bus_cmd_wmask(cmd_wmask),
    .i_bus_rsp_valid(rsp_valid), .o_bus_rsp_ready(rsp_ready), .i_bus_rsp_rdata(rsp_rdata),
    .i_bus_rsp_err(rsp_err),
    .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_data(wb_data), .o_wb_info(wb_info),
    .flush(flush)
  );

  typedef struct {
    logic [31:0]   data;
    logic [IW-1:0] info;
  } wb_exp_t;

  wb_exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] mk_info(input logic [4:0] rob, input logic [31:0] pc,
                                            input logic [15:0] excp);
    return {rob, pc, 1'b0, excp};
  endfunction

  // {lsu_ready, cmd_valid, rsp_ready, wb_valid}
  function automatic logic [3:0] hs();
    return {lsu_ready, cmd_valid, rsp_ready, wb_valid};
  endfunction

  task automatic drive_req(input logic rd, input logic uns, input logic [2:0] sz,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm, input logic [IW-1:0] info);
    chk("ready_idle", 64'(lsu_ready), 64'd1);
    lsu_valid = 1; lsu_read = rd; lsu_unsigned = uns;
    {lsu_word, lsu_short, lsu_byte} = sz;
    lsu_addr = addr; lsu_wdata = wd; lsu_wmask = wm; lsu_info = info;
    tick();
    lsu_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_info = '0;
  endtask

  task automatic bus_txn(input int cmd_wait, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] wm, input int rsp_wait,
                         input logic [31:0] rdata, input logic err);
    chk("cmd_phase", 64'(hs()), 64'b0100);
    for (int i = 0; i < cmd_wait; i++) begin
      chk("cmd_stall_addr", {31'd0, cmd_read, cmd_addr}, {31'd0, rd, addr});
      chk("cmd_stall_wdata", {28'd0, cmd_wdata, cmd_wmask}, {28'd0, wd, wm});
      tick();
    end
    chk("cmd_addr", {31'd0, cmd_read, cmd_addr}, {31'd0, rd, addr});
    chk("cmd_wdata", {28'd0, cmd_wdata, cmd_wmask}, {28'd0, wd, wm});
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    chk("rsp_phase", 64'(hs()), 64'b0010);
    for (int i = 0; i < rsp_wait; i++) tick();
    rsp_valid = 1; rsp_rdata = rdata; rsp_err = err;
    tick();
    rsp_valid = 0; rsp_err = 0; rsp_rdata = $urandom;
  endtask

  task automatic expect_wb(input int wb_wait);
    wb_exp_t e;
    chk("wb_valid", 64'(hs()), 64'b0001);
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow: observed completion expected none");
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < wb_wait; i++) begin
      chk("wb_stall_data", 64'(wb_data), 64'(e.data));
      chk("wb_stall_info", 64'(wb_info), 64'(e.info));
      tick();
    end
    chk("wb_data", 64'(wb_data), 64'(e.data));
    chk("wb_info", 64'(wb_info), 64'(e.info));
    wb_ready = 1;
    tick();
    wb_ready = 0;
    chk("back_idle", 64'(hs()), 64'b1000);
  endtask

  logic [IW-1:0] inf;

  initial begin
    tick(); tick();
    chk("rst_handshakes", 64'(hs()), 64'b1000);
    chk("rst_wb", {wb_data, wb_info[31:0]}, 64'd0);
    chk("rst_wb_info_hi", 64'(wb_info), 64'd0);
    chk("rst_cmd", {cmd_addr, cmd_wdata}, 64'd0);
    chk("rst_cmd_rm", {59'd0, cmd_read, cmd_wmask}, 64'd0);
    rst_n = 1;
    tick();

    // load byte signed, lane 3
    inf = mk_info(5'd1, 32'h0000_0100, 16'h0);
    sb.push_back('{data: 32'hFFFF_FF80, info: inf});
    drive_req(1, 0, 3'b001, 32'h0000_1003, 32'h1111_1111, 4'h8, inf);
    bus_txn(0, 1, 32'h0000_1000, 32'h1111_1111, 4'h8, 0, 32'h80FF_0000, 0);
    expect_wb(0);

    // load half unsigned, upper half
    inf = mk_info(5'd2, 32'h0000_0104, 16'h0);
    sb.push_back('{data: 32'h0000_BEEF, info: inf});
    drive_req(1, 1, 3'b010, 32'h0000_2002, 32'h0, 4'hC, inf);
    bus_txn(0, 1, 32'h0000_2000, 32'h0, 4'hC, 1, 32'hBEEF_1234, 0);
    expect_wb(0);

    // load half signed, lower half
    inf = mk_info(5'd3, 32'h0000_0108, 16'h0);
    sb.push_back('{data: 32'hFFFF_8001, info: inf});
    drive_req(1, 0, 3'b010, 32'h0000_2000, 32'h0, 4'h3, inf);
    bus_txn(0, 1, 32'h0000_2000, 32'h0, 4'h3, 0, 32'h1234_8001, 0);
    expect_wb(0);

    // load byte unsigned, lane 1
    inf = mk_info(5'd4, 32'h0000_010C, 16'h0);
    sb.push_back('{data: 32'h0000_00A5, info: inf});
    drive_req(1, 1, 3'b001, 32'h0000_0041, 32'h0, 4'h2, inf);
    bus_txn(0, 1, 32'h0000_0040, 32'h0, 4'h2, 0, 32'h0000_A500, 0);
    expect_wb(0);

    // load word
    inf = mk_info(5'd5, 32'h0000_0110, 16'h0);
    sb.push_back('{data: 32'hCAFE_F00D, info: inf});
    drive_req(1, 0, 3'b100, 32'h0000_0050, 32'h0, 4'hF, inf);
    bus_txn(0, 1, 32'h0000_0050, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 0);
    expect_wb(0);

    // store word with command and writeback back-pressure
    inf = mk_info(5'd6, 32'h0000_0114, 16'h0);
    sb.push_back('{data: 32'h0, info: inf});
    drive_req(0, 0, 3'b100, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, inf);
    bus_txn(5, 0, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF, 0, 32'h1234_5678, 0);
    expect_wb(2);

    // AGU exception: straight to writeback
    inf = mk_info(5'd7, 32'h0000_0118, 16'h0010);
    sb.push_back('{data: 32'h0, info: inf});
    drive_req(1, 0, 3'b100, 32'h0000_0062, 32'h0, 4'hF, inf);
    expect_wb(0);

    // load access fault
    inf = mk_info(5'd8, 32'h0000_011C, 16'h0);
    sb.push_back('{data: 32'h0, info: mk_info(5'd8, 32'h0000_011C, 16'h0020)});
    drive_req(1, 0, 3'b100, 32'h0000_0070, 32'h0, 4'hF, inf);
    bus_txn(0, 1, 32'h0000_0070, 32'h0, 4'hF, 0, 32'hFFFF_FFFF, 1);
    expect_wb(0);

    // store access fault
    inf = mk_info(5'd9, 32'h0000_0120, 16'h0);
    sb.push_back('{data: 32'h0, info: mk_info(5'd9, 32'h0000_0120, 16'h0080)});
    drive_req(0, 0, 3'b001, 32'h0000_0083, 32'h5A5A_5A5A, 4'h8, inf);
    bus_txn(0, 0, 32'h0000_0080, 32'h5A5A_5A5A, 4'h8, 0, 32'h0, 1);
    expect_wb(0);

    // flush in RSP, response three cycles later is drained
    drive_req(1, 0, 3'b100, 32'h0000_0090, 32'h0, 4'hF, mk_info(5'd10, 32'h124, 16'h0));
    chk("fl_cmd", 64'(hs()), 64'b0100);
    cmd_ready = 1; tick(); cmd_ready = 0;
    chk("fl_rsp", 64'(hs()), 64'b0010);
    flush = 1; tick(); flush = 0;
    chk("drain_1", 64'(hs()), 64'b0010);
    tick();
    chk("drain_2", 64'(hs()), 64'b0010);
    tick();
    chk("drain_3", 64'(hs()), 64'b0010);
    rsp_valid = 1; rsp_rdata = 32'h1357_9BDF; tick(); rsp_valid = 0;
    chk("drain_done", 64'(hs()), 64'b1000);

    // flush in CMD without handshake
    drive_req(1, 0, 3'b100, 32'h0000_00A0, 32'h0, 4'hF, mk_info(5'd11, 32'h128, 16'h0));
    flush = 1; tick(); flush = 0;
    chk("fl_cmd_idle", 64'(hs()), 64'b1000);

    // flush in CMD coinciding with the handshake
    drive_req(1, 0, 3'b100, 32'h0000_00B0, 32'h0, 4'hF, mk_info(5'd12, 32'h12C, 16'h0));
    flush = 1; cmd_ready = 1; tick(); flush = 0; cmd_ready = 0;
    chk("fl_cmdhs_drain", 64'(hs()), 64'b0010);
    rsp_valid = 1; tick(); rsp_valid = 0;
    chk("fl_cmdhs_idle", 64'(hs()), 64'b1000);

    // flush in RSP coinciding with the response
    drive_req(1, 0, 3'b100, 32'h0000_00B4, 32'h0, 4'hF, mk_info(5'd13, 32'h130, 16'h0));
    cmd_ready = 1; tick(); cmd_ready = 0;
    flush = 1; rsp_valid = 1; tick(); flush = 0; rsp_valid = 0;
    chk("fl_rsphs_idle", 64'(hs()), 64'b1000);

    // flush in WB drops the completion
    drive_req(1, 0, 3'b100, 32'h0000_00C1, 32'h0, 4'hF, mk_info(5'd14, 32'h134, 16'h0010));
    chk("fl_wb_pre", 64'(hs()), 64'b0001);
    flush = 1; tick(); flush = 0;
    chk("fl_wb_idle", 64'(hs()), 64'b1000);

    // cancelled request consumed, no bus activity
    lsu_valid = 1; lsu_cancel = 1; lsu_addr = 32'h0000_00D0;
    tick();
    lsu_valid = 0; lsu_cancel = 0;
    chk("cancel_idle", 64'(hs()), 64'b1000);
    tick();
    chk("cancel_idle2", 64'(hs()), 64'b1000);

    // request accepted while flush is high is dropped
    lsu_valid = 1; flush = 1; lsu_addr = 32'h0000_00D4;
    tick();
    lsu_valid = 0; flush = 0;
    chk("flush_accept_drop", 64'(hs()), 64'b1000);

    // asynchronous reset mid-transaction
    drive_req(1, 0, 3'b100, 32'h0000_00E0, 32'h0, 4'hF, mk_info(5'd15, 32'h138, 16'h0));
    chk("rst_mid_pre", 64'(hs()), 64'b0100);
    #2 rst_n = 0; #1;
    chk("rst_mid_hs", 64'(hs()), 64'b1000);
    chk("rst_mid_cmd", {cmd_addr, 32'd0}, 64'd0);
    tick();
    rst_n = 1;
    tick();
    chk("rst_mid_after", 64'(hs()), 64'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
